// File: rtl/i2c_slave_responder.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, 7-bit address match, write bytes with ACK.
// Define I2C_SLAVE_READ_EN to add master-read (TX) support; without it reads to SLAVE_ADDR are NACKed.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic [7:0] tx_data,
  output logic       tx_req
);

`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s;
  logic start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] sample_byte;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       ack_drv_q, ack_drv_d;
  logic       rw_q, rw_d;
  logic       tx_req_q, tx_req_d;
`ifdef I2C_SLAVE_READ_EN
  logic [7:0] tx_shift_q, tx_shift_d;
`else
  logic       unused_tx_data;
  assign unused_tx_data = ^tx_data;
`endif

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_s       = sda_sync_q[SYNC_STAGES-1];
  assign start_det   = scl_s && scl_prev_q && sda_prev_q && !sda_s;
  assign stop_det    = scl_s && scl_prev_q && !sda_prev_q && sda_s;
  assign scl_rise    = scl_s && !scl_prev_q;
  assign scl_fall    = !scl_s && scl_prev_q;
  assign sample_byte = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    ack_drv_d  = ack_drv_q;
    rw_d       = rw_q;
    tx_req_d   = 1'b0;
`ifdef I2C_SLAVE_READ_EN
    tx_shift_d = tx_shift_q;
`endif
    // Bus conditions override whatever bit-level work the current state is doing.
    if (start_det) begin
      state_d   = S_ADDR;
      cnt_d     = 4'd0;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      cnt_d     = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = sample_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            rw_d  = sample_byte[0];
            if (sample_byte[7:1] == SLAVE_ADDR && (!sample_byte[0] || READ_EN))
              state_d = S_ADDR_ACK;
            else
              state_d = S_IGNORE;
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!ack_drv_q) begin
            sda_oe_d  = 1'b1;
            busy_d    = 1'b1;
            ack_drv_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            ack_drv_d = 1'b0;
            cnt_d     = 4'd0;
`ifdef I2C_SLAVE_READ_EN
            // The ACK release fall is also where the first read bit must appear.
            if (rw_q) begin
              state_d    = S_TX;
              tx_req_d   = 1'b1;
              sda_oe_d   = ~tx_data[7];
              tx_shift_d = {tx_data[6:0], 1'b0};
              cnt_d      = 4'd1;
            end else begin
              state_d = S_RX;
            end
`else
            state_d = rw_q ? S_IGNORE : S_RX;
`endif
          end
        end
        S_RX: if (scl_rise) begin
          shift_d = sample_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = S_RX_ACK;
          end
        end
        S_RX_ACK: if (scl_fall) begin
          if (!ack_drv_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            ack_drv_d  = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            ack_drv_d = 1'b0;
            cnt_d     = 4'd0;
            state_d   = S_RX;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        S_TX: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_TX_ACK;
          end else begin
            sda_oe_d   = ~tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            cnt_d      = cnt_q + 4'd1;
          end
        end
        S_TX_ACK: if (scl_rise) begin
          if (!sda_s) begin
            tx_req_d   = 1'b1;
            tx_shift_d = tx_data;
            cnt_d      = 4'd0;
            state_d    = S_TX;
          end else begin
            state_d = S_IGNORE;
          end
        end
`endif
        S_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_drv_q  <= 1'b0;
      rw_q       <= 1'b0;
      tx_req_q   <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      tx_shift_q <= 8'h00;
`endif
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      ack_drv_q  <= ack_drv_d;
      rw_q       <= rw_d;
      tx_req_q   <= tx_req_d;
`ifdef I2C_SLAVE_READ_EN
      tx_shift_q <= tx_shift_d;
`endif
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign tx_req   = tx_req_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-level I2C master with a transaction-level model of expected ACKs, bytes and tx_req.
module tb_i2c_slave_responder;
  localparam logic [6:0] ADDR = 7'h42;
`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, scl_m, sda_m;
  logic [7:0] tx_data;
  logic scl_in, sda_in, sda_oe, rx_valid, busy, tx_req;
  logic [7:0] rx_data;

  always #5 clk = ~clk;
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_data(tx_data), .tx_req(tx_req)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit chk_en = 1'b0;
  bit exp_oe = 1'b0;
  bit never_oe = 1'b0;
  bit rx_valid_prev = 1'b0;
  bit addressed = 1'b0;
  int tx_req_cnt = 0;
  int exp_txreq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model's expected line behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_en) check("sda_oe_bit", sda_oe, exp_oe);
      if (never_oe) check("sda_oe_quiet", sda_oe, 1'b0);
      if (rx_valid) begin
        got_q.push_back(rx_data);
        check("rx_valid_width", rx_valid_prev, 1'b0);
      end
      if (tx_req) tx_req_cnt++;
      rx_valid_prev = rx_valid;
    end
  end

  task automatic wait_q;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_c;
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic stop_c;
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
    addressed = 1'b0;
  endtask

  task automatic clock_bit(input bit b, input bit e_oe, output bit seen);
    sda_m = b; wait_q();
    scl_m = 1'b1; exp_oe = e_oe; chk_en = 1'b1;
    wait_q();
    seen = sda_in;
    wait_q();
    chk_en = 1'b0; scl_m = 1'b0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_addr, input int nbits);
    bit seen;
    bit exp_ack;
    for (int i = 0; i < nbits; i++) clock_bit(b[7-i], 1'b0, seen);
    if (nbits == 8) begin
      if (is_addr) begin
        addressed = (b[7:1] == ADDR) && (!b[0] || READ_EN);
        if (addressed && b[0]) exp_txreq++;
      end else if (addressed) begin
        exp_q.push_back(b);
      end
      exp_ack = addressed;
      clock_bit(1'b1, exp_ack, seen);
      check("ack_bus", seen, !exp_ack);
      $display("txn byte=%02h addr_phase=%0d ack=%0d", b, is_addr, !seen);
    end else begin
      $display("txn partial byte=%02h bits=%0d", b, nbits);
    end
  endtask

  task automatic read_byte(input bit mack, input logic [7:0] model_tx, output logic [7:0] got);
    bit seen;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, ~model_tx[7-i], seen);
      got[7-i] = seen;
    end
    clock_bit(!mack, 1'b0, seen);
    if (mack) exp_txreq++;
    else addressed = 1'b0;
    $display("txn read byte=%02h master_ack=%0d", got, mack);
  endtask

  task automatic verify_rx(input string name, output int n);
    n = got_q.size();
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({name, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b1, b2;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_req", tx_req, 1'b0);
    rst = 1'b0;
    wait_q();

    // Single write: address 0x42/W, data A5.
    start_c();
    send_byte(8'h84, 1'b1, 8);
    check("busy_addressed", busy, 1'b1);
    send_byte(8'hA5, 1'b0, 8);
    stop_c();
    verify_rx("write1", n);
    check("write1_pulses", n, 1);
    check("write1_rx_data", rx_data, 8'hA5);
    check("write1_busy_after_stop", busy, 1'b0);

    // Wrong address 0x43: never drives SDA.
    never_oe = 1'b1;
    start_c();
    send_byte(8'h86, 1'b1, 8);
    check("wrong_addr_busy", busy, 1'b0);
    send_byte(8'h11, 1'b0, 8);
    stop_c();
    never_oe = 1'b0;
    verify_rx("wrong_addr", n);
    check("wrong_addr_pulses", n, 0);
    check("wrong_addr_rx_data", rx_data, 8'hA5);

    // Repeated START between two writes.
    start_c();
    send_byte(8'h84, 1'b1, 8);
    send_byte(8'h3C, 1'b0, 8);
    start_c();
    send_byte(8'h84, 1'b1, 8);
    send_byte(8'hC3, 1'b0, 8);
    stop_c();
    verify_rx("restart", n);
    check("restart_pulses", n, 2);
    check("restart_rx_data", rx_data, 8'hC3);

    // Truncated byte: 4 bits then STOP.
    start_c();
    send_byte(8'h84, 1'b1, 8);
    send_byte(8'hB0, 1'b0, 4);
    stop_c();
    verify_rx("trunc", n);
    check("trunc_pulses", n, 0);
    check("trunc_rx_data", rx_data, 8'hC3);
    check("trunc_busy", busy, 1'b0);

    // Read: address 0x42/R, master ACK then NACK.
    tx_data = 8'h5A;
    tx_req_cnt = 0;
    exp_txreq = 0;
    start_c();
    send_byte(8'h85, 1'b1, 8);
    if (addressed) begin
      read_byte(1'b1, tx_data, b1);
      check("read1_byte", b1, 8'h5A);
      read_byte(1'b0, tx_data, b2);
      check("read2_byte", b2, 8'h5A);
    end
    stop_c();
    check("read_tx_req_count", tx_req_cnt, exp_txreq);
    check("read_busy_after_stop", busy, 1'b0);
    verify_rx("read", n);
    check("read_pulses", n, 0);

    // Write after read shows the bus recovered to idle.
    start_c();
    send_byte(8'h84, 1'b1, 8);
    send_byte(8'h77, 1'b0, 8);
    send_byte(8'h08, 1'b0, 8);
    stop_c();
    verify_rx("write2", n);
    check("write2_pulses", n, 2);
    check("write2_rx_data", rx_data, 8'h08);

    // Reset in the middle of an addressed write.
    start_c();
    send_byte(8'h84, 1'b1, 8);
    send_byte(8'hE0, 1'b0, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    stop_c();
    verify_rx("midrst", n);
    check("midrst_pulses", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
